eth_rx_mac_filter: RTL and testbench
====================================

ETH_RX_MAC_FILTER -- requirements
Module: eth_rx_mac_filter

Interface
REQ-001 SHALL have parameter: ACCEPT_BROADCAST, 1, nonzero accepts destination ff:ff:ff:ff:ff:ff.
REQ-002 SHALL have parameter: ACCEPT_MULTICAST, 0, nonzero accepts any destination with bit 0 of first byte set.
REQ-003 SHALL have port: clock  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  64/8/1/1/1/1  AXIS frames from MAC RX FIFO; byte 0 at tdata[7:0].
REQ-006 SHALL have ports: m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  64/8/1/1/1/1  filtered frames.
REQ-007 SHALL have port: cfg_local_mac  input  48  station address; [47:40] is first wire byte.
REQ-008 SHALL have port: cfg_promisc  input  1  accept all frames.
REQ-009 SHALL have ports: stat_pass_count, stat_drop_count  output  32 each  frame counters (see Configuration).

Function
REQ-010 SHALL implement states HEAD (awaiting first beat), PASS, DROP.
REQ-011 In HEAD, the accepted first beat SHALL decide the frame: dest = tdata[47:0], byte-reversed against cfg_local_mac.
REQ-012 Accept if cfg_promisc, or dest == cfg_local_mac, or (ACCEPT_BROADCAST and dest all ones), or (ACCEPT_MULTICAST and tdata[0]); else drop.
REQ-013 A first beat with tlast=1 and tkeep[5:0] != 6'h3f (runt) SHALL be dropped regardless of REQ-012.
REQ-014 HEAD -> PASS on accept with tlast=0; HEAD -> DROP on drop with tlast=0; single-beat frames remain in HEAD.
REQ-015 PASS/DROP -> HEAD on accepted beat with tlast=1.
REQ-016 cfg_* SHALL be sampled only at the first beat; changes mid-frame SHALL NOT affect the current frame.
REQ-017 Passed beats SHALL appear on m_axis exactly one cycle after s_axis acceptance, tdata/tkeep/tlast/tuser unmodified.
REQ-018 Output SHALL be one register stage; s_axis_tready = !m_axis_tvalid || m_axis_tready, giving full throughput.
REQ-019 In DROP, and for a dropped first beat, s_axis_tready SHALL be 1 irrespective of m_axis_tready; dropped beats SHALL NOT assert m_axis_tvalid.
REQ-020 m_axis outputs SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 tuser (bad-frame) SHALL pass through; the filter SHALL NOT itself discard frames with tuser=1.

Reset
REQ-022 Reset SHALL force state HEAD, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast/tuser=0, counters 0.
REQ-023 Reset asserted mid-frame SHALL discard the in-flight frame; the next accepted beat after release is treated as a first beat.
REQ-024 s_axis_tready SHALL be 0 while reset is asserted.

Configuration
REQ-025 Macro ETH_RX_FILTER_STATS_EN defined: stat_pass_count increments on each passed frame's last beat entering the output stage; stat_drop_count on each dropped frame's last beat; both wrap 32'hffffffff -> 0.
REQ-026 Macro ETH_RX_FILTER_STATS_EN undefined: counters not built; stat_pass_count and stat_drop_count tied to 0.

Verification
REQ-027 cfg_local_mac=48'h02_00_00_00_00_01, 3-beat frame tdata[47:0]=48'h01_00_00_00_00_02, m_axis_tready=1 -> same 3 beats out, each 1 cycle later; pass_count=1.
REQ-028 Same MAC, frame to 48'h03_00_00_00_00_02 (dest 02:00:00:00:00:03), 4 beats -> s_axis_tready=1 all beats, no m_axis_tvalid; drop_count=1.
REQ-029 Broadcast frame, ACCEPT_BROADCAST=1, m_axis_tready toggling 1/0 per cycle -> all beats delivered in order, outputs stable during stalls, no beat lost or duplicated.
REQ-030 Single beat tlast=1, tkeep=8'h0f, matching MAC -> dropped as runt; drop_count=1.
REQ-031 Reset pulse on beat 2 of a 5-beat passing frame -> m_axis_tvalid=0 immediately; remaining beats 3-5 treated as new frame head and filtered on beat 3's tdata.
REQ-032 Back-to-back frames pass, drop, pass with tvalid continuously 1 -> exactly frames 1 and 3 delivered with no idle cycle between their beats.

Source files
------------

// File: rtl/eth_rx_mac_filter.sv
// Destination-address filter for 64-bit AXI-Stream receive frames with one output register stage.
// Optional frame counters are built when ETH_RX_FILTER_STATS_EN is defined.
module eth_rx_mac_filter #(
    parameter int ACCEPT_BROADCAST = 1,
    parameter int ACCEPT_MULTICAST = 0
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,

    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,

    input  logic [47:0] cfg_local_mac,
    input  logic        cfg_promisc,

    output logic [31:0] stat_pass_count,
    output logic [31:0] stat_drop_count
);

    typedef enum logic [1:0] {
        HEAD,
        PASS,
        DROP
    } state_t;

    state_t state;
    state_t state_next;

    logic [47:0] dest_mac;
    logic        is_unicast_hit;
    logic        is_broadcast;
    logic        is_multicast;
    logic        is_runt;
    logic        head_accept;
    logic        beat_passes;
    logic        out_ready;
    logic        s_fire;
    logic        load;

    // Byte 0 on the wire sits in tdata[7:0] but is the MSB of the station address.
    assign dest_mac = {s_axis_tdata[7:0],   s_axis_tdata[15:8],  s_axis_tdata[23:16],
                       s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]};

    assign is_unicast_hit = (dest_mac == cfg_local_mac);
    assign is_broadcast   = (ACCEPT_BROADCAST != 0) && (dest_mac == 48'hffff_ffff_ffff);
    assign is_multicast   = (ACCEPT_MULTICAST != 0) && s_axis_tdata[0];
    assign is_runt        = s_axis_tlast && (s_axis_tkeep[5:0] != 6'h3f);
    assign head_accept    = !is_runt && (cfg_promisc || is_unicast_hit || is_broadcast || is_multicast);

    // Configuration only matters in HEAD; afterwards the decision lives in the state.
    assign beat_passes = (state == PASS) || ((state == HEAD) && head_accept);
    assign out_ready   = !m_axis_tvalid || m_axis_tready;

    // Dropped beats never touch the output stage, so they are swallowed without back-pressure.
    assign s_axis_tready = !reset && (beat_passes ? out_ready : 1'b1);
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign load          = s_fire && beat_passes;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= HEAD;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default is assigned before the case so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            HEAD: begin
                if (s_fire && !s_axis_tlast) begin
                    state_next = head_accept ? PASS : DROP;
                end
            end
            PASS, DROP: begin
                if (s_fire && s_axis_tlast) begin
                    state_next = HEAD;
                end
            end
            default: state_next = HEAD;
        endcase
    end

    // Output register: loads only when empty or draining, so a stalled beat holds stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tuser  <= s_axis_tuser;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef ETH_RX_FILTER_STATS_EN
    logic [31:0] pass_count;
    logic [31:0] drop_count;

    // Counters wrap naturally at 32 bits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pass_count <= '0;
            drop_count <= '0;
        end else begin
            if (load && s_axis_tlast) begin
                pass_count <= pass_count + 32'd1;
            end
            if (s_fire && !beat_passes && s_axis_tlast) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

    assign stat_pass_count = pass_count;
    assign stat_drop_count = drop_count;
`else
    assign stat_pass_count = 32'd0;
    assign stat_drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Scoreboard bench for eth_rx_mac_filter: the driver queues expected passed beats, a monitor pops them.
// Counter expectations follow ETH_RX_FILTER_STATS_EN as the RTL is built.
module tb_eth_rx_mac_filter;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MATCH_HDR = 48'h01_00_00_00_00_02;
    localparam logic [47:0] OTHER_HDR = 48'h03_00_00_00_00_02;
    localparam logic [47:0] BCAST_HDR = 48'hff_ff_ff_ff_ff_ff;
    localparam logic [47:0] MCAST_HDR = 48'h01_00_00_5e_00_01;
    localparam logic [47:0] RAND_HDR  = 48'h66_55_44_33_22_11;
    localparam logic [47:0] MISS_HDR  = 48'h0a_0b_0c_0d_0e_0f;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [47:0] cfg_local_mac = LOCAL_MAC;
    logic        cfg_promisc = 1'b0;
    logic [31:0] stat_pass_count;
    logic [31:0] stat_drop_count;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        int          cyc;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    strict = 1'b1;
    int    ready_mode = 0;
    int    exp_pass = 0;
    int    exp_drop = 0;

    eth_rx_mac_filter #(
        .ACCEPT_BROADCAST(1),
        .ACCEPT_MULTICAST(0)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .cfg_local_mac  (cfg_local_mac),
        .cfg_promisc    (cfg_promisc),
        .stat_pass_count(stat_pass_count),
        .stat_drop_count(stat_drop_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Sink readiness: 0 = always ready, 1 = toggle each cycle, 2 = held off.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                1:       m_axis_tready = ~m_axis_tready;
                2:       m_axis_tready = 1'b0;
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] beat_data(input logic [47:0] hdr, input int fid, input int k);
        if (k == 0) return {8'(fid), 8'ha5, hdr};
        return {8'(fid), 8'(k), 16'hc0de, 8'(fid), 8'(k), 16'hbeef};
    endfunction

    // Present one beat, wait for the handshake, and queue it if it is expected to pass.
    task automatic drive_beat(input logic [63:0] data, input logic [7:0] keep, input logic last,
                              input logic user, input logic pass);
        bit    done = 1'b0;
        beat_t b;
        s_axis_tdata  = data;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clock);
            if (!pass && t == 0) check("drop_ready", 64'(s_axis_tready), 64'd1);
            if (s_axis_tready) begin
                done = 1'b1;
                if (pass) begin
                    b.data = data;
                    b.keep = keep;
                    b.last = last;
                    b.user = user;
                    b.cyc  = cyc;
                    exp_q.push_back(b);
                end
            end
            @(posedge clock);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no s_axis_tready, expected handshake for %h", data);
        end
    endtask

    task automatic send_frame(input logic [47:0] hdr, input int fid, input int nbeats,
                              input logic [7:0] last_keep, input logic last_user,
                              input logic pass, input bit mid_cfg);
        for (int k = 0; k < nbeats; k++) begin
            logic is_last;
            is_last = (k == nbeats - 1);
            drive_beat(beat_data(hdr, fid, k), is_last ? last_keep : 8'hff, is_last,
                       is_last ? last_user : 1'b0, pass);
            if (k == 0 && mid_cfg) begin
                cfg_promisc   = 1'b1;
                cfg_local_mac = {hdr[7:0], hdr[15:8], hdr[23:16], hdr[31:24], hdr[39:32], hdr[47:40]};
            end
        end
        if (mid_cfg) begin
            cfg_promisc   = 1'b0;
            cfg_local_mac = LOCAL_MAC;
        end
        if (pass) exp_pass++;
        else exp_drop++;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
            @(posedge clock);
            #1;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_stats();
`ifdef ETH_RX_FILTER_STATS_EN
        check("pass_count", 64'(stat_pass_count), 64'(exp_pass));
        check("drop_count", 64'(stat_drop_count), 64'(exp_drop));
`else
        check("pass_count", 64'(stat_pass_count), 64'd0);
        check("drop_count", 64'(stat_drop_count), 64'd0);
`endif
    endtask

    // Monitor: pops on every output handshake and checks hold-stability across stalls.
    initial begin
        beat_t       e;
        bit          stall_prev = 1'b0;
        logic [63:0] hold_data;
        logic [7:0]  hold_keep;
        logic        hold_last;
        logic        hold_user;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", 64'(m_axis_tvalid), 64'd1);
                    check("stall_data", m_axis_tdata, hold_data);
                    check("stall_ctrl", {m_axis_tkeep, m_axis_tlast, m_axis_tuser},
                          {hold_keep, hold_last, hold_user});
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %h, expected no output", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", m_axis_tdata, e.data);
                        check("out_ctrl", {m_axis_tkeep, m_axis_tlast, m_axis_tuser},
                              {e.keep, e.last, e.user});
                        if (strict) check("out_latency", 64'(cyc), 64'(e.cyc + 1));
                    end
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                hold_data  = m_axis_tdata;
                hold_keep  = m_axis_tkeep;
                hold_last  = m_axis_tlast;
                hold_user  = m_axis_tuser;
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no completion, expected finish before 200000 ns");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #12;
        check("rst_s_ready", 64'(s_axis_tready), 64'd0);
        check("rst_m_valid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_data", m_axis_tdata, 64'd0);
        check("rst_m_ctrl", {m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 64'd0);
        check_stats();
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(2);

        // Unicast match, 3 beats, exact one-cycle latency.
        send_frame(MATCH_HDR, 1, 3, 8'h07, 1'b0, 1'b1, 1'b0);
        idle(3);
        drain();
        check_stats();

        // Unicast miss, 4 beats, swallowed.
        send_frame(OTHER_HDR, 2, 4, 8'hff, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_stats();

        // Broadcast with a toggling sink.
        strict     = 1'b0;
        ready_mode = 1;
        send_frame(BCAST_HDR, 3, 5, 8'h3f, 1'b0, 1'b1, 1'b0);
        idle(2);
        drain();
        ready_mode = 0;
        idle(3);
        strict = 1'b1;

        // Runt single beat to our own address, then multicast with multicast disabled.
        send_frame(MATCH_HDR, 4, 1, 8'h0f, 1'b0, 1'b0, 1'b0);
        send_frame(MCAST_HDR, 5, 3, 8'hff, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_stats();

        // Promiscuous pass with a bad-frame flag, then a miss whose cfg changes mid-frame.
        cfg_promisc = 1'b1;
        send_frame(RAND_HDR, 6, 2, 8'h01, 1'b1, 1'b1, 1'b0);
        cfg_promisc = 1'b0;
        send_frame(RAND_HDR, 7, 3, 8'hff, 1'b0, 1'b0, 1'b1);
        idle(3);
        drain();
        check_stats();

        // Sink held off: a full-keep single beat parks in the output, a miss still flows through.
        strict     = 1'b0;
        ready_mode = 2;
        idle(2);
        send_frame(MATCH_HDR, 8, 1, 8'h3f, 1'b0, 1'b1, 1'b0);
        send_frame(MISS_HDR, 9, 2, 8'hff, 1'b0, 1'b0, 1'b0);
        idle(4);
        ready_mode = 0;
        drain();
        idle(2);
        strict = 1'b1;
        check_stats();

        // Back-to-back pass, drop, pass with tvalid never dropping.
        send_frame(MATCH_HDR, 10, 3, 8'hff, 1'b0, 1'b1, 1'b0);
        send_frame(OTHER_HDR, 11, 2, 8'hff, 1'b0, 1'b0, 1'b0);
        send_frame(MATCH_HDR, 12, 2, 8'h03, 1'b0, 1'b1, 1'b0);
        idle(3);
        drain();
        check_stats();

        // Reset after beat 2 of a passing frame; beats 3-5 form a new frame that misses.
        drive_beat(beat_data(MATCH_HDR, 13, 0), 8'hff, 1'b0, 1'b0, 1'b1);
        drive_beat(beat_data(MATCH_HDR, 13, 1), 8'hff, 1'b0, 1'b0, 1'b1);
        reset         = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        check("mid_rst_m_valid", 64'(m_axis_tvalid), 64'd0);
        check("mid_rst_s_ready", 64'(s_axis_tready), 64'd0);
        exp_q.delete();
        exp_pass = 0;
        exp_drop = 0;
        check_stats();
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive_beat(beat_data(MISS_HDR, 13, 0), 8'hff, 1'b0, 1'b0, 1'b0);
        drive_beat(beat_data(MISS_HDR, 13, 3), 8'hff, 1'b0, 1'b0, 1'b0);
        drive_beat(beat_data(MISS_HDR, 13, 4), 8'h01, 1'b1, 1'b0, 1'b0);
        exp_drop++;
        idle(4);
        drain();
        check_stats();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
